// File: rtl/sequence_generator_1011.sv
// Serial frame transmitter for the 1011 sync-marker link: marker 1011, payload
// MSB-first with optional zero-stuffing, then a fixed gap of idle zeros.
module sequence_generator_1011 #(
    parameter int DATA_WIDTH = 8,
    parameter int IDLE_BITS  = 2,
    parameter int STUFF_EN   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  sequence_out,
    output logic                  marker_out,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(DATA_WIDTH);
    localparam logic [3:0]    GAP_LAST = 4'(IDLE_BITS - 1);
    localparam bit            STUFF_ON = (STUFF_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARKER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bit_cnt;
    logic [1:0]            r_mark_idx;
    logic [3:0]            r_gap_cnt;
    logic [2:0]            r_hist;
    logic                  r_seq;
    logic                  r_marker;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_bit_cnt_nxt;
    logic [1:0]            w_mark_idx_nxt;
    logic [3:0]            w_gap_cnt_nxt;
    logic [2:0]            w_hist_nxt;
    logic                  w_bit;
    logic                  w_marker;
    logic                  w_done;
    logic                  w_stuff;

    assign data_ready   = (r_state == ST_IDLE);
    assign sequence_out = r_seq;
    assign marker_out   = r_marker;
    assign frame_done   = r_done;

    // A stuffed zero breaks a pending 101 so the receiver never sees 1011 in the payload.
    assign w_stuff = STUFF_ON && (r_hist == 3'b101);

    // Next-state, datapath and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_mark_idx_nxt = r_mark_idx;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_bit          = 1'b0;
        w_marker       = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (data_valid) begin
                    w_state_nxt    = ST_MARKER;
                    w_shift_nxt    = data_in;
                    w_bit_cnt_nxt  = LOAD_CNT;
                    w_mark_idx_nxt = 2'd1;
                    w_bit          = 1'b1;
                    w_marker       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MARKER: begin
                // Marker tail after the leading 1 is 0,1,1 for indices 1..3.
                w_bit    = (r_mark_idx != 2'd1);
                w_marker = 1'b1;
                if (r_mark_idx == 2'd3) begin
                    w_state_nxt    = ST_PAYLOAD;
                    w_mark_idx_nxt = 2'd0;
                end else begin
                    w_mark_idx_nxt = r_mark_idx + 2'd1;
                end
            end
            ST_PAYLOAD: begin
                if (w_stuff) begin
                    w_bit = 1'b0;
                end else begin
                    w_bit         = r_shift[DATA_WIDTH-1];
                    w_shift_nxt   = r_shift << 1;
                    w_bit_cnt_nxt = r_bit_cnt - CW'(1);
                    if (r_bit_cnt == CW'(1)) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_done        = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = 4'd0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_IDLE) begin
            w_hist_nxt = 3'b000;
        end else begin
            w_hist_nxt = {r_hist[1:0], w_bit};
        end
    end

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_mark_idx <= 2'd0;
            r_gap_cnt  <= 4'd0;
            r_hist     <= 3'b000;
            r_seq      <= 1'b0;
            r_marker   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_mark_idx <= w_mark_idx_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_hist     <= w_hist_nxt;
            r_seq      <= w_bit;
            r_marker   <= w_marker;
            r_done     <= w_done;
        end
    end

endmodule
